// File: rtl/fetch_unit.sv
// fetch_unit: single-byte instruction fetcher between control unit and memory.
// Sequence: IDLE -> READ (wait for mem_ready) -> DONE (one cycle) -> IDLE.
// Optional macro FETCH_TIMEOUT_EN adds a READ watchdog and the sticky fetch_err output.
`timescale 1ns/1ps

module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iri_out,
    input  logic        pcc,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  irin,
    output logic        iri_in,
    output logic [15:0] pc,
    output logic        busy
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        fetch_err
`endif
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WD_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic                iri_out_q;
    logic                jmp_pend_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic [PC_W-1:0]     mem_addr_q;
    logic                mem_rd_q;
    logic [BYTE_W-1:0]   irin_q;
    logic                iri_in_q;
    logic                busy_q;

    logic                fetch_start;
    logic                fetch_done;
    logic                wd_expire;
    logic [BYTE_W-1:0]   fetch_byte;

`ifdef FETCH_TIMEOUT_EN
    logic [WD_W-1:0]     wd_q;
    logic                fetch_err_q;

    // Watchdog fires on the READ cycle that would bring the count to its ceiling.
    assign wd_expire = (state_q == S_READ) && !mem_ready
                       && (wd_q == WD_W'((1 << WD_W) - 2));

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q        <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            if (fetch_start) begin
                wd_q <= '0;
            end else if ((state_q == S_READ) && !mem_ready) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (wd_expire) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign wd_expire = 1'b0;
`endif

    // Fetch start/completion qualifiers; a timed-out fetch delivers a zero byte.
    always_comb begin
        fetch_start = (state_q == S_IDLE) && iri_out && !iri_out_q;
        fetch_done  = (state_q == S_READ) && (mem_ready || wd_expire);
        fetch_byte  = mem_ready ? mem_data : BYTE_W'(0);
    end

    // Next PC: jump wins everywhere; READ ignores pcc and skips the post-fetch
    // increment once a jump has landed during that READ.
    always_comb begin
        pc_d = pc_q;
        if (jmp) begin
            pc_d = jmp_addr;
        end else if (state_q == S_READ) begin
            if (fetch_done && !jmp_pend_q) begin
                pc_d = pc_q + PC_W'(1);
            end
        end else if (pcc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // Fetch FSM with registered memory/control-unit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            iri_out_q  <= 1'b0;
            jmp_pend_q <= 1'b0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            irin_q     <= '0;
            iri_in_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            iri_out_q <= iri_out;
            pc_q      <= pc_d;
            iri_in_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fetch_start) begin
                        state_q    <= S_READ;
                        mem_addr_q <= pc_q;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        jmp_pend_q <= 1'b0;
                    end
                end
                S_READ: begin
                    if (fetch_done) begin
                        state_q    <= S_DONE;
                        irin_q     <= fetch_byte;
                        mem_rd_q   <= 1'b0;
                        iri_in_q   <= 1'b1;
                        jmp_pend_q <= 1'b0;
                    end else if (jmp) begin
                        jmp_pend_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign irin     = irin_q;
    assign iri_in   = iri_in_q;
    assign pc       = pc_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized fetch/idle
// transactions checked against a transaction-level PC/instruction model.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iri_out;
    logic        pcc;
    logic        jmp;
    logic [15:0] jmp_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  irin;
    logic        iri_in;
    logic [15:0] pc;
    logic        busy;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iri_out   (iri_out),
        .pcc       (pcc),
        .jmp       (jmp),
        .jmp_addr  (jmp_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .irin      (irin),
        .iri_in    (iri_in),
        .pc        (pc),
        .busy      (busy)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: architectural PC and last delivered instruction byte.
    logic [15:0] m_pc;
    logic [7:0]  m_irin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        iri_out   = 1'b0;
        pcc       = 1'b0;
        jmp       = 1'b0;
        jmp_addr  = 16'h0000;
        mem_data  = 8'h00;
        mem_ready = 1'b0;
    endtask

    // Idle cycles with random jmp/pcc and stray mem_ready strobes.
    task automatic idle_ops(input int n);
        for (int i = 0; i < n; i++) begin
            iri_out   = 1'b0;
            jmp       = ($urandom % 4) == 0;
            jmp_addr  = 16'($urandom);
            pcc       = ($urandom % 3) == 0;
            mem_ready = 1'($urandom % 2);
            mem_data  = 8'($urandom);
            if (jmp) m_pc = jmp_addr;
            else if (pcc) m_pc = m_pc + 16'd1;
            step();
            check("idle_pc", 32'(pc), 32'(m_pc));
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_iri_in", 32'(iri_in), 32'd0);
            check("idle_mem_rd", 32'(mem_rd), 32'd0);
            check("idle_irin", 32'(irin), 32'(m_irin));
        end
        clear_inputs();
    endtask

    // One fetch: 'waits' READ cycles before mem_ready; jmp on READ cycle jmp_at (-1 none).
    task automatic do_fetch(input int waits, input int jmp_at, input logic [15:0] ja,
                            input logic [7:0] data);
        logic [15:0] addr;
        bit          jumped;
        logic        hold;
        addr   = m_pc;
        jumped = 1'b0;
        hold   = 1'($urandom % 2);
        clear_inputs();
        iri_out = 1'b1;
        step();
        check("start_mem_rd", 32'(mem_rd), 32'd1);
        check("start_mem_addr", 32'(mem_addr), 32'(addr));
        check("start_busy", 32'(busy), 32'd1);
        check("start_iri_in", 32'(iri_in), 32'd0);
        iri_out = hold;
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            mem_data  = (w == waits) ? data : 8'($urandom);
            jmp       = (w == jmp_at);
            jmp_addr  = jmp ? ja : 16'($urandom);
            pcc       = 1'($urandom % 2);
            if (jmp) begin
                jumped = 1'b1;
                m_pc   = ja;
            end
            step();
            if (w < waits) begin
                check("read_mem_rd", 32'(mem_rd), 32'd1);
                check("read_mem_addr", 32'(mem_addr), 32'(addr));
                check("read_pc", 32'(pc), 32'(m_pc));
                check("read_iri_in", 32'(iri_in), 32'd0);
            end
        end
        if (!jumped) m_pc = m_pc + 16'd1;
        m_irin = data;
        check("done_iri_in", 32'(iri_in), 32'd1);
        check("done_irin", 32'(irin), 32'(m_irin));
        check("done_pc", 32'(pc), 32'(m_pc));
        check("done_mem_rd", 32'(mem_rd), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        clear_inputs();
        mem_ready = 1'($urandom % 2);
        mem_data  = 8'($urandom);
        step();
        check("post_iri_in", 32'(iri_in), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_irin", 32'(irin), 32'(m_irin));
        check("post_pc", 32'(pc), 32'(m_pc));
        clear_inputs();
    endtask

    initial begin
        int pulses;
        int waits;
        int jat;

        rst_n = 1'b0;
        clear_inputs();
        m_pc   = 16'h0000;
        m_irin = 8'h00;
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_irin", 32'(irin), 32'd0);
        check("rst_iri_in", 32'(iri_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef FETCH_TIMEOUT_EN
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic zero-wait fetch from pc 0.
        do_fetch(0, -1, 16'h0000, 8'hA5);

        // PC wrap on fetch from 0xFFFF.
        jmp = 1'b1;
        jmp_addr = 16'hFFFF;
        m_pc = 16'hFFFF;
        step();
        check("jmp_idle_pc", 32'(pc), 32'hFFFF);
        clear_inputs();
        do_fetch(0, -1, 16'h0000, 8'h3C);
        check("wrap_pc", 32'(pc), 32'h0000);

        // Jump in first READ cycle, data two cycles later, pcc toggling in READ.
        do_fetch(2, 0, 16'h1234, 8'hC3);
        check("jmp_read_pc", 32'(pc), 32'h1234);

        // Jump coinciding with mem_ready.
        do_fetch(1, 1, 16'hBEEF, 8'h5E);

        // iri_out held high for 10 cycles with zero-wait memory.
        pulses = 0;
        iri_out = 1'b1;
        mem_ready = 1'b1;
        mem_data = 8'h77;
        for (int i = 0; i < 10; i++) begin
            step();
            if (iri_in) pulses++;
        end
        clear_inputs();
        step();
        m_pc = m_pc + 16'd1;
        m_irin = 8'h77;
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_pc", 32'(pc), 32'(m_pc));
        check("held_irin", 32'(irin), 32'(m_irin));

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            idle_ops(int'($urandom % 4));
            waits = int'($urandom % 5);
            jat   = int'($urandom % 7) - 1;
            if (jat > waits) jat = -1;
            do_fetch(waits, jat, 16'($urandom), 8'($urandom));
        end

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: watchdog completes the fetch with a zero byte.
        check("pre_to_fetch_err", 32'(fetch_err), 32'd0);
        iri_out = 1'b1;
        step();
        iri_out = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c < 15) begin
                check("to_wait_iri_in", 32'(iri_in), 32'd0);
                check("to_wait_mem_rd", 32'(mem_rd), 32'd1);
            end
        end
        m_pc = m_pc + 16'd1;
        m_irin = 8'h00;
        check("to_iri_in", 32'(iri_in), 32'd1);
        check("to_irin", 32'(irin), 32'd0);
        check("to_pc", 32'(pc), 32'(m_pc));
        check("to_fetch_err", 32'(fetch_err), 32'd1);
        step();
        do_fetch(0, -1, 16'h0000, 8'h11);
        check("to_err_sticky", 32'(fetch_err), 32'd1);
`endif

        // Reset while READ is pending abandons the fetch.
        if (m_pc == 16'h0000) begin
            pcc = 1'b1;
            m_pc = 16'h0001;
            step();
            clear_inputs();
        end
        iri_out = 1'b1;
        step();
        check("prerst_mem_rd", 32'(mem_rd), 32'd1);
        iri_out = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_irin", 32'(irin), 32'd0);
`ifdef FETCH_TIMEOUT_EN
        check("midrst_fetch_err", 32'(fetch_err), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        m_pc = 16'h0000;
        m_irin = 8'h00;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            mem_data = 8'($urandom);
            step();
            if (iri_in) pulses++;
            check("postrst_mem_rd", 32'(mem_rd), 32'd0);
        end
        clear_inputs();
        check("postrst_pulses", 32'(pulses), 32'd0);
        check("postrst_pc", 32'(pc), 32'd0);

        // iri_out already high when reset releases counts as an edge.
        rst_n = 1'b0;
        iri_out = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        do_fetch(1, -1, 16'h0000, 8'h5A);
        check("relhigh_pc", 32'(pc), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
